// File: rtl/posit_encoder.sv
// Posit encoder: turns (sign, regime k, exponent, mantissa) fields into a WIDTH-bit posit
// with exponent field width EN. Two-stage valid/ready pipeline:
//   S1 builds the unrounded body plus guard/sticky bits and the saturation flags.
//   S2 rounds, saturates, applies the sign and holds the output register.
// Optional feature: define POSIT_ENC_ROUND_EN for round-to-nearest-even; otherwise the body
// is truncated.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   sign                POS / NEG
//   regime              signed regime value k
//   exponent            exponent, only bits [EN-1:0] used
//   mantissa            1.fffffff, bit 7 (hidden one) ignored
//   in_zero, in_nar     special encodings (in_nar wins)
//   out_valid/out_ready output handshake
//   out_posit           encoded posit

package posit_pkg;
  typedef enum logic {
    POS = 1'b0,
    NEG = 1'b1
  } sign_t;
endpackage

module posit_encoder #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned EN    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  posit_pkg::sign_t       sign,
  input  logic signed [7:0]      regime,
  input  logic signed [7:0]      exponent,
  input  logic [7:0]             mantissa,
  input  logic                   in_zero,
  input  logic                   in_nar,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_posit
);

  localparam int unsigned BW = WIDTH - 1;   // body width
  localparam int unsigned TW = EN + 7;      // exponent + fraction tail width
  localparam int unsigned FW = WIDTH + 16;  // scratch width, wide enough for any unsaturated body
  localparam int signed   KMax = int'(WIDTH) - 2;
  localparam int signed   KMin = 1 - int'(WIDTH);

  // Stage 1 state
  logic                   r1_valid;
  logic [BW-1:0]          r1_body;
  logic                   r1_guard;
  logic                   r1_sticky;
  posit_pkg::sign_t       r1_sign;
  logic                   r1_zero;
  logic                   r1_nar;
  logic                   r1_sat_max;
  logic                   r1_sat_min;

  // Stage 2 state
  logic                   r2_valid;
  logic [WIDTH-1:0]       r2_posit;

  logic                   w_s2_adv;
  logic signed [31:0]     w_k;
  logic [31:0]            w_rlen;
  logic [FW-1:0]          w_regime;
  logic [FW-1:0]          w_full;
  logic [TW-1:0]          w_tail;
  logic                   w_sat_max;
  logic                   w_sat_min;
  logic [BW-1:0]          w_body;
  logic                   w_carry;
  logic [BW-1:0]          w_body_rnd;
  logic [FW-1:0]          w_neg;
  logic [WIDTH-1:0]       w_posit;
  logic                   w_unused;

  // S1 may move into S2 whenever S2 is empty or S2 is being drained this cycle.
  assign w_s2_adv  = !r2_valid || out_ready;
  assign in_ready  = !r1_valid || w_s2_adv;
  assign out_valid = r2_valid;
  assign out_posit = r2_posit;

  if (EN == 0) begin : g_no_exp
    assign w_tail = mantissa[6:0];
  end else begin : g_exp
    assign w_tail = {exponent[EN-1:0], mantissa[6:0]};
  end

  // S1: regime field left-aligned in a wide scratch vector, tail appended right after it.
  always_comb begin
    w_k       = {{24{regime[7]}}, regime};
    w_sat_max = (w_k >= KMax);
    w_sat_min = (w_k <= KMin);
    if (w_k >= 0) begin
      w_rlen   = w_k + 2;
      w_regime = ~({FW{1'b1}} >> (w_k + 1));
    end else begin
      w_rlen   = 1 - w_k;
      w_regime = {1'b1, {(FW - 1){1'b0}}} >> (-w_k);
    end
    w_full = w_regime | ({w_tail, {(FW - TW){1'b0}}} >> w_rlen);
  end

  // S2: rounding
`ifdef POSIT_ENC_ROUND_EN
  logic          w_inc;
  logic [FW-1:0] w_sum;
  always_comb begin
    w_inc      = r1_guard && (r1_body[0] || r1_sticky);
    w_sum      = FW'(r1_body) + FW'(w_inc);
    w_carry    = w_sum[BW];
    w_body_rnd = w_sum[BW-1:0];
  end
  assign w_unused = ^{exponent, mantissa[7], w_neg[FW-1:WIDTH], w_sum[FW-1:BW+1]};
`else
  always_comb begin
    w_carry    = 1'b0;
    w_body_rnd = r1_body;
  end
  assign w_unused = ^{exponent, mantissa[7], w_neg[FW-1:WIDTH], r1_guard, r1_sticky};
`endif

  // S2: saturation, sign and special values
  always_comb begin
    if (r1_sat_max || w_carry) begin
      w_body = {BW{1'b1}};
    end else if (r1_sat_min || (w_body_rnd == '0)) begin
      w_body = {{(BW - 1){1'b0}}, 1'b1};
    end else begin
      w_body = w_body_rnd;
    end
    w_neg = FW'(0) - FW'({1'b0, w_body});
    if (r1_nar) begin
      w_posit = {1'b1, {BW{1'b0}}};
    end else if (r1_zero) begin
      w_posit = '0;
    end else if (r1_sign == posit_pkg::NEG) begin
      w_posit = w_neg[WIDTH-1:0];
    end else begin
      w_posit = {1'b0, w_body};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid   <= 1'b0;
      r1_body    <= '0;
      r1_guard   <= 1'b0;
      r1_sticky  <= 1'b0;
      r1_sign    <= posit_pkg::POS;
      r1_zero    <= 1'b0;
      r1_nar     <= 1'b0;
      r1_sat_max <= 1'b0;
      r1_sat_min <= 1'b0;
      r2_valid   <= 1'b0;
      r2_posit   <= '0;
    end else begin
      if (in_ready) begin
        r1_valid <= in_valid;
        if (in_valid) begin
          r1_body    <= w_full[FW-1 -: BW];
          r1_guard   <= w_full[FW-1-BW];
          r1_sticky  <= |w_full[FW-2-BW:0];
          r1_sign    <= sign;
          r1_zero    <= in_zero;
          r1_nar     <= in_nar;
          r1_sat_max <= w_sat_max;
          r1_sat_min <= w_sat_min;
        end
      end
      if (w_s2_adv) begin
        r2_valid <= r1_valid;
        if (r1_valid) begin
          r2_posit <= w_posit;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// Self-checking bench for posit_encoder (WIDTH=7, EN=1): directed cases, backpressure,
// mid-flight reset and a randomized stream against a bit-queue reference model.
module tb_posit_encoder;
  import posit_pkg::*;

  localparam int W  = 7;
  localparam int EN = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  sign_t             sign;
  logic signed [7:0] regime;
  logic signed [7:0] exponent;
  logic [7:0]        mantissa;
  logic              in_zero;
  logic              in_nar;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_posit;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  posit_encoder #(
    .WIDTH(W),
    .EN   (EN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sign     (sign),
    .regime   (regime),
    .exponent (exponent),
    .mantissa (mantissa),
    .in_zero  (in_zero),
    .in_nar   (in_nar),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_posit(out_posit)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // Reference: lay the posit bits out one by one, then cut, round and saturate.
  function automatic int ref_enc(input bit neg, input int k, input logic [7:0] e,
                                 input logic [7:0] m, input bit z, input bit n);
    bit q[$];
    int body;
    int maxb;
    maxb = (1 << (W - 1)) - 1;
    if (n) return 1 << (W - 1);
    if (z) return 0;
    if (k >= W - 2) body = maxb;
    else if (k <= -(W - 1)) body = 1;
    else begin
      if (k >= 0) begin
        repeat (k + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-k) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = EN - 1; i >= 0; i--) q.push_back(e[i]);
      for (int i = 6; i >= 0; i--) q.push_back(m[i]);
      body = 0;
      for (int i = 0; i < W - 1; i++) body = body * 2 + int'(q[i]);
`ifdef POSIT_ENC_ROUND_EN
      begin
        bit guard;
        bit sticky;
        guard  = q[W-1];
        sticky = 1'b0;
        for (int i = W; i < q.size(); i++) sticky |= q[i];
        if (guard && ((body % 2 == 1) || sticky)) body += 1;
        if (body > maxb) body = maxb;
      end
`endif
      if (body == 0) body = 1;
    end
    if (neg) return ((1 << W) - body) % (1 << W);
    return body;
  endfunction

  // Scoreboard: every valid output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) check_eq("sb_unexpected", 32'(exp_q.size()), 32'd1);
        else check_eq("sb_data", 32'(out_posit), 32'(exp_q[0]));
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_enc(sign == NEG, int'(regime), exponent, mantissa, in_zero, in_nar));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input sign_t s, input int k, input logic [7:0] e, input logic [7:0] m,
                       input logic z, input logic n);
    sign     = s;
    regime   = 8'(k);
    exponent = e;
    mantissa = m;
    in_zero  = z;
    in_nar   = n;
  endtask

  task automatic send(input sign_t s, input int k, input logic [7:0] e, input logic [7:0] m,
                      input logic z, input logic n);
    logic acc;
    acc = 1'b0;
    drive(s, k, e, m, z, n);
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      acc = in_ready;
      tick();
      if (acc) break;
    end
    in_valid = 1'b0;
    check_eq("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic one(input string tag, input sign_t s, input int k, input logic [7:0] e,
                     input logic [7:0] m, input logic z, input logic n, input int want);
    out_ready = 1'b1;
    send(s, k, e, m, z, n);
    check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    check_eq({tag, "_lat2"}, 32'(out_valid), 32'd1);
    check_eq(tag, 32'(out_posit), 32'(want));
  endtask

  initial begin
    int ks[3];
    int exps[3];
    int idx;
    int acc_cnt;
    int got;
    logic a;
    logic ov;
    logic [W-1:0] op;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(POS, 0, 8'h00, 8'h80, 1'b0, 1'b0);
    #2;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_posit", 32'(out_posit), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    one("pos_one", POS, 0, 8'h00, 8'h80, 1'b0, 1'b0, 'h20);
    one("neg_one", NEG, 0, 8'h00, 8'h80, 1'b0, 1'b0, 'h60);
    one("zero", NEG, 3, 8'h01, 8'hff, 1'b1, 1'b0, 'h00);
    one("nar", POS, 0, 8'h00, 8'h80, 1'b1, 1'b1, 'h40);
    one("maxpos", POS, 5, 8'h00, 8'h80, 1'b0, 1'b0, 'h3f);
    one("minpos", POS, -6, 8'h00, 8'h80, 1'b0, 1'b0, 'h01);
    one("neg_maxpos", NEG, 5, 8'h00, 8'h80, 1'b0, 1'b0, 'h41);
`ifdef POSIT_ENC_ROUND_EN
    one("round", POS, 0, 8'h01, 8'hf8, 1'b0, 1'b0, 'h30);
`else
    one("round", POS, 0, 8'h01, 8'hf8, 1'b0, 1'b0, 'h2f);
`endif
    tick();

    // Backpressure: two accepts fill the pipe, third waits.
    ks   = '{0, 1, -1};
    exps = '{'h20, 'h30, 'h10};
    out_ready = 1'b0;
    idx = 0;
    acc_cnt = 0;
    drive(POS, ks[0], 8'h00, 8'h80, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      a = in_ready;
      tick();
      if (a && idx < 3) begin
        idx++;
        acc_cnt++;
        if (idx < 3) drive(POS, ks[idx], 8'h00, 8'h80, 1'b0, 1'b0);
      end
    end
    check_eq("bp_accepts", 32'(acc_cnt), 32'd2);
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
    check_eq("bp_hold_posit", 32'(out_posit), 32'(exps[0]));
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      ov = out_valid;
      op = out_posit;
      a  = in_valid && in_ready;
      tick();
      if (ov) begin
        check_eq("bp_order", 32'(op), 32'(exps[got]));
        got++;
      end
      if (a) begin
        idx++;
        in_valid = 1'b0;
      end
    end
    check_eq("bp_count", 32'(got), 32'd3);
    tick();

    // Reset with both stages full.
    out_ready = 1'b0;
    send(POS, 2, 8'h00, 8'h80, 1'b0, 1'b0);
    send(NEG, 1, 8'h01, 8'hc0, 1'b0, 1'b0);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_out_posit", 32'(out_posit), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("post_rst_idle", 32'(out_valid), 32'd0);
    end
    one("post_rst", NEG, -1, 8'h00, 8'h80, 1'b0, 1'b0, 'h70);
    tick();

    // Randomized stream with random backpressure; the scoreboard checks every output.
    for (int c = 0; c < 400; c++) begin
      sign      = ($urandom_range(0, 1) == 1) ? NEG : POS;
      regime    = 8'(int'($urandom_range(0, 16)) - 8);
      exponent  = 8'($urandom);
      mantissa  = 8'($urandom);
      in_zero   = ($urandom_range(0, 15) == 0);
      in_nar    = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
    check_eq("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/posit_encoder.md
POSIT_ENCODER -- requirements
Module: posit_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 7, posit bus width in bits (legal range 4..8).
REQ-002 SHALL have parameter EN, default 1, exponent field width in bits (legal range 0..2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: the input fields are valid.
REQ-006 SHALL have port in_ready, output, 1: the encoder accepts the input this cycle.
REQ-007 SHALL have port sign, input, sign_t (common package): POS or NEG.
REQ-008 SHALL have port regime, input, signed 8: the regime value k.
REQ-009 SHALL have port exponent, input, signed 8; only bits [EN-1:0] are used and the upper bits are ignored.
REQ-010 SHALL have port mantissa, input, unsigned 8, format 1.fffffff; bit 7 is the hidden one and is ignored.
REQ-011 SHALL have port in_zero, input, 1: encode zero and ignore the other fields.
REQ-012 SHALL have port in_nar, input, 1: encode NaR and ignore the other fields; it has priority over in_zero.
REQ-013 SHALL have port out_valid, output, 1: out_posit is valid.
REQ-014 SHALL have port out_ready, input, 1: the consumer accepts out_posit.
REQ-015 SHALL have port out_posit, output, WIDTH: the encoded posit.

Function
REQ-016 SHALL be a 2-stage pipeline:
- S1 builds the unrounded body, guard bit and sticky bit.
- S2 rounds, saturates, applies the sign and drives the output.
REQ-017 SHALL use valid/ready on both sides; a transfer occurs on a rising edge with valid and ready both high.
REQ-018 SHALL have latency 2 cycles from input transfer to out_valid, with throughput of 1 per cycle while out_ready=1.
REQ-019 SHALL drive in_ready = !S1_valid || S1 advancing; S1 advances when !S2_valid || out_ready.
REQ-020 SHALL hold out_posit and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL encode the regime field:
- k>=0: k+1 ones, then a zero.
- k<0: -k zeros, then a one.
REQ-022 SHALL form the body as regime field, then exp[EN-1:0], then mantissa[6:0], MSB-first, truncated to WIDTH-1 bits.
REQ-023 SHALL take guard = first dropped bit and sticky = OR of all later dropped bits.
REQ-024 SHALL saturate k>=WIDTH-2 to maxpos, body all ones, with no rounding applied.
REQ-025 SHALL saturate k<=-(WIDTH-1) to minpos, body 0...01, with no rounding applied.
REQ-026 SHALL saturate rounding results:
- a carry out of the body yields maxpos;
- a zero body from a nonzero input yields minpos.
REQ-027 SHALL output {1'b0, body} for POS.
REQ-028 SHALL output the WIDTH-bit two's complement of {1'b0, body} for NEG.
REQ-029 SHALL output all zeros for in_zero and {1'b1, zeros} for in_nar, regardless of sign.
REQ-030 SHALL compute all intermediate arithmetic at least WIDTH+8 bits wide with no overflow.

Reset
REQ-031 SHALL on rst_n=0 immediately clear S1_valid, S2_valid and out_valid, and set out_posit to 0.
REQ-032 SHALL drive in_ready=1 during reset.
REQ-033 SHALL discard any in-flight data on reset mid-operation; the first output after release comes from a new input.

Configuration
REQ-034 SHALL, with POSIT_ENC_ROUND_EN defined, round to nearest even: increment the body when guard && (body_lsb || sticky).
REQ-035 SHALL, without POSIT_ENC_ROUND_EN, truncate the body, with REQ-024, REQ-025 and REQ-026 still applying.

Verification (WIDTH=7, EN=1)
REQ-036 SHALL pass: POS, k=0, exp=0, mantissa=0x80, out_ready=1 -> out_posit=0x20 exactly 2 cycles after acceptance.
REQ-037 SHALL pass: NEG, k=0, exp=0, mantissa=0x80 -> 0x60; in_zero -> 0x00; in_nar+in_zero -> 0x40.
REQ-038 SHALL pass: k=5 -> 0x3F; k=-6 -> 0x01; NEG k=5 -> 0x41.
REQ-039 SHALL pass: POS, k=0, exp=1, mantissa=0xF8 -> 0x30 with POS_ENC round macro POSIT_ENC_ROUND_EN defined, and 0x2F without it.
REQ-040 SHALL pass: 3 back-to-back inputs with out_ready=0 -> in_ready drops after 2 accepts and out_posit holds; on raising out_ready, all 3 outputs appear in order.
REQ-041 SHALL pass: rst_n pulsed low with both stages full -> out_valid=0 within the same cycle and no stale output after release.
